// File: rtl/wb_stage.sv
// Writeback stage: one-entry register between execute/memory and the regfile.
// Optional perf counters (perf_retired, perf_load_stall) are enabled by WB_PERF_CNT_EN.
module wb_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RF_AW       = 5,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_rvalid,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [1:0]       wb_sel,
  output logic             fwd_valid,
  output logic             mem_err
`ifdef WB_PERF_CNT_EN
  ,
  output logic [63:0]      perf_retired,
  output logic [63:0]      perf_load_stall
`endif
);

  localparam int unsigned OB = $clog2(XLEN / 8);
  localparam logic [1:0] SEL_MEM  = 2'd0;
  localparam logic [1:0] SEL_ALU  = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;
  localparam logic [31:0] TO_LAST = (MEM_TIMEOUT == 0) ? '0 : 32'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_MEM} state_t;

  function automatic logic [1:0] decode_sel(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0010111, 7'b0110111: return SEL_ALU;
      7'b1101111, 7'b1100111:                         return SEL_PC4;
      7'b0000011:                                     return SEL_MEM;
      default:                                        return SEL_NONE;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [4:0]       ld_rd_q, ld_rd_d;
  logic [2:0]       ld_f3_q, ld_f3_d;
  logic [OB-1:0]    ld_off_q, ld_off_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             we_d, err_d;
  logic [RF_AW-1:0] waddr_d;
  logic [XLEN-1:0]  wdata_d;
  logic [1:0]       sel_d, in_sel;
  logic [XLEN-1:0]  shifted, ld_val;
  logic             ld_ok, accept;
  logic             unused_inst;

  // Only opcode, rd and funct3 matter to writeback.
  assign unused_inst = ^in_inst[31:15];

  assign in_ready  = (state_q != WAIT_MEM);
  assign accept    = in_valid && in_ready;
  assign in_sel    = decode_sel(in_inst[6:0]);
  assign fwd_valid = rf_we;

  // Misaligned accesses simply take the low lanes at the byte offset.
  always_comb begin
    shifted = mem_rdata >> {ld_off_q, 3'b000};
    ld_val  = '0;
    ld_ok   = 1'b1;
    case (ld_f3_q)
      3'b000:  ld_val = XLEN'($signed(shifted[7:0]));
      3'b001:  ld_val = XLEN'($signed(shifted[15:0]));
      3'b010:  ld_val = XLEN'($signed(shifted[31:0]));
      3'b100:  ld_val = XLEN'(shifted[7:0]);
      3'b101:  ld_val = XLEN'(shifted[15:0]);
      3'b110:  ld_val = XLEN'(shifted[31:0]);
      3'b011: begin
        if (XLEN == 64) ld_val = shifted;
        else            ld_ok  = 1'b0;
      end
      default: ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ld_rd_d  = ld_rd_q;
    ld_f3_d  = ld_f3_q;
    ld_off_d = ld_off_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    waddr_d  = rf_waddr;
    wdata_d  = rf_wdata;
    sel_d    = wb_sel;
    err_d    = mem_err;

    case (state_q)
      WAIT_MEM: begin
        cnt_d = cnt_q + 32'd1;
        if (mem_rvalid) begin
          state_d = IDLE;
          if (ld_ok && ld_rd_q != 5'd0) begin
            we_d    = 1'b1;
            waddr_d = RF_AW'(ld_rd_q);
            wdata_d = ld_val;
          end
        end else if (MEM_TIMEOUT != 0 && cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      sel_d    = in_sel;
      cnt_d    = '0;
      ld_rd_d  = in_inst[11:7];
      ld_f3_d  = in_inst[14:12];
      ld_off_d = in_alu[OB-1:0];
      if (in_sel == SEL_MEM) begin
        state_d = WAIT_MEM;
      end else begin
        state_d = HOLD;
        if (in_sel != SEL_NONE && in_inst[11:7] != 5'd0) begin
          we_d    = 1'b1;
          waddr_d = RF_AW'(in_inst[11:7]);
          wdata_d = (in_sel == SEL_ALU) ? in_alu : in_pc + XLEN'(4);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ld_rd_q  <= '0;
      ld_f3_q  <= '0;
      ld_off_q <= '0;
      cnt_q    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_sel   <= SEL_NONE;
      mem_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_rd_q  <= ld_rd_d;
      ld_f3_q  <= ld_f3_d;
      ld_off_q <= ld_off_d;
      cnt_q    <= cnt_d;
      rf_we    <= we_d;
      rf_waddr <= waddr_d;
      rf_wdata <= wdata_d;
      wb_sel   <= sel_d;
      mem_err  <= err_d;
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired    <= '0;
      perf_load_stall <= '0;
    end else begin
      if (accept && in_sel != SEL_MEM) perf_retired <= perf_retired + 64'd1;
      else if (state_q == WAIT_MEM && mem_rvalid) perf_retired <= perf_retired + 64'd1;
      if (state_q == WAIT_MEM) perf_load_stall <= perf_load_stall + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (XLEN=32, MEM_TIMEOUT=4): vector table plus load/timeout/reset sequences.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_alu = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  wb_sel;
  logic        fwd_valid;
  logic        mem_err;
`ifdef WB_PERF_CNT_EN
  logic [63:0] perf_retired;
  logic [63:0] perf_load_stall;
`endif

  int unsigned n_vec = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  wb_stage #(.XLEN(32), .RF_AW(5), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_alu(in_alu),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_sel(wb_sel), .fwd_valid(fwd_valid), .mem_err(mem_err)
`ifdef WB_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_load_stall(perf_load_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  sel;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] rdata;
    int unsigned delay;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } lvec_t;

  vec_t  tv[14];
  lvec_t lv[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_wr(input string nm, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    check({nm, ".rf_we"}, 32'(rf_we), 32'(we));
    check({nm, ".fwd_valid"}, 32'(fwd_valid), 32'(we));
    check({nm, ".rf_waddr"}, 32'(rf_waddr), 32'(wa));
    check({nm, ".rf_wdata"}, rf_wdata, wd);
  endtask

  task automatic run_load(input int idx, input lvec_t v);
    string nm;
    nm = $sformatf("load%0d", idx);
    @(negedge clk);
    in_valid   = 1'b1;
    in_inst    = v.inst;
    in_alu     = v.alu;
    mem_rvalid = 1'b1;            // must be ignored in the accept cycle
    mem_rdata  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check({nm, ".wb_sel"}, 32'(wb_sel), 32'd0);
    for (int unsigned i = 1; i <= v.delay; i++) begin
      check({nm, ".in_ready_wait"}, 32'(in_ready), 32'd0);
      check({nm, ".rf_we_wait"}, 32'(rf_we), 32'd0);
      @(negedge clk);
      in_valid   = 1'b0;
      mem_rvalid = (i == v.delay);
      mem_rdata  = v.rdata;
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    check_wr(nm, v.we, v.waddr, v.wdata);
    check({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    n_vec++;
  endtask

  initial begin
    // inst, pc, alu, we, waddr, wdata, sel -- waddr/wdata hold when we=0
    tv[0]  = '{32'h00A282B3, 32'h0000_0100, 32'h0000_1234, 1'b1, 5'd5,  32'h0000_1234, 2'd1}; // ADD x5
    tv[1]  = '{32'h000000EF, 32'hFFFF_FFFC, 32'h0000_0010, 1'b1, 5'd1,  32'h0000_0000, 2'd2}; // JAL x1 wrap
    tv[2]  = '{32'h0062A023, 32'h0000_0104, 32'h0000_0055, 1'b0, 5'd1,  32'h0000_0000, 2'd3}; // SW
    tv[3]  = '{32'h00000013, 32'h0000_0108, 32'h0000_0099, 1'b0, 5'd1,  32'h0000_0000, 2'd1}; // ADDI x0
    tv[4]  = '{32'h00100393, 32'h0000_010C, 32'h0000_DEAD, 1'b1, 5'd7,  32'h0000_DEAD, 2'd1}; // ADDI x7
    tv[5]  = '{32'h00000537, 32'h0000_0110, 32'hABCD_E000, 1'b1, 5'd10, 32'hABCD_E000, 2'd1}; // LUI x10
    tv[6]  = '{32'h00000597, 32'h0000_0114, 32'h0000_1000, 1'b1, 5'd11, 32'h0000_1000, 2'd1}; // AUIPC x11
    tv[7]  = '{32'h00000167, 32'h0000_0200, 32'h0000_0300, 1'b1, 5'd2,  32'h0000_0204, 2'd2}; // JALR x2
    tv[8]  = '{32'h00208463, 32'h0000_0300, 32'h0000_0001, 1'b0, 5'd2,  32'h0000_0204, 2'd3}; // BEQ
    tv[9]  = '{32'h0000000F, 32'h0000_0304, 32'h0000_0002, 1'b0, 5'd2,  32'h0000_0204, 2'd3}; // FENCE
    tv[10] = '{32'h00000073, 32'h0000_0308, 32'h0000_0003, 1'b0, 5'd2,  32'h0000_0204, 2'd3}; // ECALL
    tv[11] = '{32'h00000033, 32'h0000_030C, 32'h0000_0004, 1'b0, 5'd2,  32'h0000_0204, 2'd1}; // ADD x0
    tv[12] = '{32'h00000FFF, 32'h0000_0310, 32'h0000_0005, 1'b0, 5'd2,  32'h0000_0204, 2'd3}; // undefined op, rd=31
    tv[13] = '{32'h00000F93, 32'h0000_0314, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF, 2'd1}; // ADDI x31

    // inst, alu, rdata, delay, we, waddr, wdata
    lv[0] = '{32'h00000183, 32'h0000_1002, 32'h0080_0000, 3, 1'b1, 5'd3,  32'hFFFF_FF80}; // LB x3
    lv[1] = '{32'h00004183, 32'h0000_1002, 32'h0080_0000, 3, 1'b1, 5'd3,  32'h0000_0080}; // LBU x3
    lv[2] = '{32'h00001203, 32'h0000_2000, 32'h1234_8001, 1, 1'b1, 5'd4,  32'hFFFF_8001}; // LH x4
    lv[3] = '{32'h00005203, 32'h0000_2000, 32'h1234_8001, 2, 1'b1, 5'd4,  32'h0000_8001}; // LHU x4
    lv[4] = '{32'h00002303, 32'h0000_3000, 32'hCAFE_BABE, 1, 1'b1, 5'd6,  32'hCAFE_BABE}; // LW x6
    lv[5] = '{32'h00003303, 32'h0000_3000, 32'h1111_1111, 1, 1'b0, 5'd6,  32'hCAFE_BABE}; // LD on RV32
    lv[6] = '{32'h00002003, 32'h0000_3000, 32'h2222_2222, 2, 1'b0, 5'd6,  32'hCAFE_BABE}; // LW x0
    lv[7] = '{32'h00001203, 32'h0000_2003, 32'h8000_0000, 1, 1'b1, 5'd4,  32'h0000_0080}; // LH misaligned
    lv[8] = '{32'h00006483, 32'h0000_4000, 32'h8765_4321, 1, 1'b1, 5'd9,  32'h8765_4321}; // LWU x9
    lv[9] = '{32'h00007483, 32'h0000_4000, 32'h3333_3333, 1, 1'b0, 5'd9,  32'h8765_4321}; // funct3=111

    repeat (2) @(posedge clk);
    #1;
    check_wr("reset", 1'b0, 5'd0, 32'h0);
    check("reset.wb_sel", 32'(wb_sel), 32'd3);
    check("reset.mem_err", 32'(mem_err), 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    n_vec++;
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back stream, one accept per cycle
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_inst  = tv[i].inst;
      in_pc    = tv[i].pc;
      in_alu   = tv[i].alu;
      @(posedge clk); #1;
      check_wr($sformatf("vec%0d", i), tv[i].we, tv[i].waddr, tv[i].wdata);
      check($sformatf("vec%0d.wb_sel", i), 32'(wb_sel), 32'(tv[i].sel));
      check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
      n_vec++;
    end

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_wr("idle", 1'b0, 5'd31, 32'hFFFF_FFFF);
    check("idle.in_ready", 32'(in_ready), 32'd1);
    n_vec++;

    for (int i = 0; i < 10; i++) run_load(i, lv[i]);

    // Timeout: no mem_rvalid for 4 wait cycles
    @(negedge clk);
    in_valid = 1'b1;
    in_inst  = 32'h00002283;
    in_alu   = 32'h0;
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("timeout.in_ready%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("timeout.mem_err%0d", i), 32'(mem_err), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("timeout.mem_err", 32'(mem_err), 32'd1);
    check("timeout.in_ready", 32'(in_ready), 32'd1);
    check_wr("timeout", 1'b0, 5'd9, 32'h8765_4321);
    n_vec++;

    @(negedge clk);
    in_valid = 1'b1;
    in_inst  = 32'h00A282B3;
    in_alu   = 32'h0000_5A5A;
    @(posedge clk); #1;
    check_wr("after_timeout", 1'b1, 5'd5, 32'h0000_5A5A);
    check("sticky.mem_err", 32'(mem_err), 32'd1);
    n_vec++;

    // Reset while a load waits, then a stale mem_rvalid
    @(negedge clk);
    in_inst = 32'h00002403;
    in_alu  = 32'h0;
    @(posedge clk); #1;
    check("rstwait.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    check_wr("rstwait", 1'b0, 5'd0, 32'h0);
    check("rstwait.mem_err", 32'(mem_err), 32'd0);
    check("rstwait.wb_sel", 32'(wb_sel), 32'd3);
    check("rstwait.in_ready_after", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check_wr("stale_rvalid", 1'b0, 5'd0, 32'h0);
    check("stale_rvalid.in_ready", 32'(in_ready), 32'd1);
    n_vec++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Parametrised writeback stage: one-entry pipeline register between execute/memory and the register file.
- Decodes writeback source (MEM / ALU / PC+4) from the held instruction and aligns/extends load data.
- Stalls the upstream stage while a load waits for variable-latency memory data.
- Drives the regfile write port and a forwarding tap.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- RF_AW, 5, register address width.
- MEM_TIMEOUT, 0, cycles a load may wait before the error flag is raised; 0 disables the check.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction
- in_pc  in  XLEN  instruction PC
- in_alu  in  XLEN  ALU result; for loads, this is the byte address
- mem_rdata  in  XLEN  raw aligned memory word
- mem_rvalid  in  1  mem_rdata valid this cycle
- rf_we  out  1  regfile write enable
- rf_waddr  out  RF_AW  destination register
- rf_wdata  out  XLEN  write data
- wb_sel  out  2  0=MEM, 1=ALU, 2=PC+4, 3=NONE
- fwd_valid  out  1  rf_waddr/rf_wdata are forwardable this cycle
- mem_err  out  1  load timeout, sticky until rst

Behaviour:
- Reset: rf_we=0, rf_waddr=0, rf_wdata=0, wb_sel=3, fwd_valid=0, mem_err=0, in_ready=1, state=IDLE, entry empty.
- States:
  - IDLE: empty.
  - HOLD: non-load instruction held.
  - WAIT_MEM: load held, data not yet returned.
- Accept: on in_valid&&in_ready the stage captures inst, pc and alu. Next state is WAIT_MEM if opcode=0000011, else HOLD.
- Source decode:
  - R-type (0110011), I-type (0010011), AUIPC (0010111), LUI (0110111) -> ALU.
  - JAL (1101111), JALR (1100111) -> PC+4.
  - LOAD -> MEM.
  - All other opcodes (store, branch, fence, system, undefined) -> NONE, no write.
- PC+4 is computed at XLEN width with wrap-around; no overflow flag.
- HOLD: rf_we=1 for exactly one cycle unless wb_sel=NONE or rd=0. in_ready=1, so back-to-back accepts are allowed at 1 instr/cycle. Without a new accept, return to IDLE.
- WAIT_MEM:
  - in_ready=0 and rf_we=0.
  - On mem_rvalid, next cycle: rf_we=1 (unless rd=0), rf_wdata=extended load value, state -> IDLE or HOLD/WAIT_MEM if a new accept occurs.
  - mem_rvalid in the acceptance cycle itself is ignored. Data is only valid from the cycle after acceptance.
- Load extension by funct3 (inst[14:12]) with byte offset alu[log2(XLEN/8)-1:0]:
  - LB=000, sign-extended byte.
  - LH=001, sign-extended half.
  - LW=010, sign-extended when XLEN=64.
  - LBU=100, LHU=101, LWU=110: zero-extended.
  - LD=011 only when XLEN=64.
  - Misaligned half/word: data is taken from the low lanes of the offset position, and no exception is raised.
  - Undefined funct3: rf_we=0.
- rd=0: rf_we is never asserted. wb_sel still reflects the decode.
- fwd_valid equals rf_we. rf_waddr/rf_wdata hold their last value when rf_we=0.
- Timeout (MEM_TIMEOUT>0): after MEM_TIMEOUT cycles in WAIT_MEM without mem_rvalid:
  - mem_err=1, the load is dropped with no write, state -> IDLE.
- rst asserted mid-WAIT_MEM: the pending load is discarded, no write occurs, and a later mem_rvalid is ignored while IDLE.
- Latency: non-load 1 cycle from accept to rf_we. Load 1 cycle after mem_rvalid.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- Defined: adds outputs perf_retired[63:0], which increments once per committed instruction including NONE-class and rd=0 but excluding timed-out loads, and perf_load_stall[63:0], which increments each cycle in WAIT_MEM. Both counters are zeroed by rst.
- Undefined: the outputs and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- ADD x5 (inst 0x00A282B3) with alu=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, wb_sel=1.
- JAL x1 at pc=0xFFFFFFFC (XLEN=32) -> rf_wdata=0x00000000, wb_sel=2.
- LB x3 with alu offset=2, mem_rvalid 3 cycles later, mem_rdata=0x00800000 -> in_ready=0 for 3 cycles, then rf_wdata=0xFFFFFF80. LBU with the same stimulus -> rf_wdata=0x00000080.
- SW, then ADDI x0 -> rf_we=0 for both; wb_sel=3 then 1.
- MEM_TIMEOUT=4, load with no mem_rvalid -> mem_err=1 after 4 wait cycles, no write, in_ready returns to 1.
- rst during WAIT_MEM, then mem_rvalid -> no rf_we. Back-to-back ADDI stream -> one write per cycle with in_ready held at 1.
